// File: rtl/core_v_mcu_pkg.sv
// ============================================================================
// Module      : core_v_mcu_pkg
// Description : Shared register offsets, reset values and encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_v_mcu_pkg;

    localparam logic [7:0]  CPU_IRQ_TIMER_MTIME_LO     = 8'h00;
    localparam logic [7:0]  CPU_IRQ_TIMER_MTIME_HI     = 8'h04;
    localparam logic [7:0]  CPU_IRQ_TIMER_MTIMECMP_LO  = 8'h08;
    localparam logic [7:0]  CPU_IRQ_TIMER_MTIMECMP_HI  = 8'h0C;
    localparam logic [7:0]  CPU_IRQ_TIMER_PRESCALE     = 8'h10;
    localparam logic [7:0]  CPU_IRQ_TIMER_IRQ_PENDING  = 8'h14;
    localparam logic [7:0]  CPU_IRQ_TIMER_IRQ_ENABLE   = 8'h18;
    localparam logic [7:0]  CPU_IRQ_TIMER_IRQ_MODE     = 8'h1C;

    localparam logic [31:0] CPU_IRQ_TIMER_MTIME_RST    = 32'h0000_0000;
    localparam logic [31:0] CPU_IRQ_TIMER_MTIMECMP_RST = 32'hFFFF_FFFF;

    localparam logic        CPU_IRQ_TIMER_MODE_LEVEL   = 1'b0;
    localparam logic        CPU_IRQ_TIMER_MODE_EDGE    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cpu_irq_sync.sv
// ============================================================================
// Module      : cpu_irq_sync
// Description : Two-flop synchroniser with rising-edge detect for one line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_irq_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_rise  = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/cpu_irq_timer.sv
// ============================================================================
// Module      : cpu_irq_timer
// Description : Machine timer (mtime/mtimecmp) and external interrupt conditioning.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_irq_timer
    import core_v_mcu_pkg::*;
#(
    parameter int NUM_IRQ = 2,
    parameter int ADDR_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                reg_req_i,
    input  logic                reg_we_i,
    input  logic [ADDR_W-1:0]   reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic                reg_gnt_o,
    output logic                reg_rvalid_o,
    output logic [31:0]         reg_rdata_o,
    input  logic [NUM_IRQ-1:0]  ext_irq_i,
    output logic [NUM_IRQ-1:0]  irq_o,
    output logic                time_irq_o
);

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic [15:0]        r_prescale;
    logic [15:0]        r_presc_cnt;
    logic               r_time_irq;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_irq;
    logic               r_rvalid;
    logic [31:0]        r_rdata;

    logic [ADDR_W-1:0]  w_addr;
    logic               w_wr;
    logic               w_rd;
    logic               w_tick;
    logic [31:0]        w_rdata;
    logic [NUM_IRQ-1:0] w_level;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic               w_unused;

    assign w_addr   = {reg_addr_i[ADDR_W-1:2], 2'b00};
    assign w_wr     = reg_req_i & reg_we_i;
    assign w_rd     = reg_req_i & ~reg_we_i;
    assign w_tick   = (r_presc_cnt == r_prescale);
    assign w_unused = ^reg_addr_i[1:0];

    assign w_w1c = (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_IRQ_PENDING))
                 ? reg_wdata_i[NUM_IRQ-1:0] : '0;

    // Edge lines: set beats W1C. Level lines: follow the synchronised input.
    assign w_pending_nxt = (r_mode & ((r_pending & ~w_w1c) | w_rise))
                         | (~r_mode & w_level);

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        cpu_irq_sync u_sync (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_async (ext_irq_i[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime     <= {CPU_IRQ_TIMER_MTIME_RST, CPU_IRQ_TIMER_MTIME_RST};
            r_mtimecmp  <= {CPU_IRQ_TIMER_MTIMECMP_RST, CPU_IRQ_TIMER_MTIMECMP_RST};
            r_prescale  <= '0;
            r_presc_cnt <= '0;
            r_time_irq  <= 1'b0;
        end else begin
            if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_PRESCALE)) begin
                r_prescale  <= reg_wdata_i[15:0];
                r_presc_cnt <= '0;
            end else if (w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + 16'd1;
            end

            // A software write to either half wins over the tick; no carry.
            if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_MTIME_LO)) begin
                r_mtime[31:0] <= reg_wdata_i;
            end else if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_MTIME_HI)) begin
                r_mtime[63:32] <= reg_wdata_i;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_MTIMECMP_LO)) begin
                r_mtimecmp[31:0] <= reg_wdata_i;
            end
            if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_MTIMECMP_HI)) begin
                r_mtimecmp[63:32] <= reg_wdata_i;
            end

            r_time_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= {NUM_IRQ{CPU_IRQ_TIMER_MODE_LEVEL}};
            r_irq     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_IRQ_ENABLE)) begin
                r_enable <= reg_wdata_i[NUM_IRQ-1:0];
            end
            if (w_wr && w_addr == ADDR_W'(CPU_IRQ_TIMER_IRQ_MODE)) begin
                r_mode <= reg_wdata_i[NUM_IRQ-1:0];
            end
            r_irq <= r_pending & r_enable;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_W'(CPU_IRQ_TIMER_MTIME_LO):    w_rdata = r_mtime[31:0];
            ADDR_W'(CPU_IRQ_TIMER_MTIME_HI):    w_rdata = r_mtime[63:32];
            ADDR_W'(CPU_IRQ_TIMER_MTIMECMP_LO): w_rdata = r_mtimecmp[31:0];
            ADDR_W'(CPU_IRQ_TIMER_MTIMECMP_HI): w_rdata = r_mtimecmp[63:32];
            ADDR_W'(CPU_IRQ_TIMER_PRESCALE):    w_rdata = {16'd0, r_prescale};
            ADDR_W'(CPU_IRQ_TIMER_IRQ_PENDING): w_rdata = 32'(r_pending);
            ADDR_W'(CPU_IRQ_TIMER_IRQ_ENABLE):  w_rdata = 32'(r_enable);
            ADDR_W'(CPU_IRQ_TIMER_IRQ_MODE):    w_rdata = 32'(r_mode);
            default:                            w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= reg_req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = r_rvalid;
    assign reg_rdata_o  = r_rdata;
    assign irq_o        = r_irq;
    assign time_irq_o   = r_time_irq;

endmodule

`default_nettype wire

// File: tb/tb_cpu_irq_timer.sv
// ============================================================================
// Module      : tb_cpu_irq_timer
// Description : Scoreboard bench for cpu_irq_timer register port, timer and IRQs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_irq_timer;
    import core_v_mcu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  ext   = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  irq;
    logic        tirq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_head;

    always #5 clk = ~clk;

    cpu_irq_timer #(.NUM_IRQ(2), .ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_req_i    (req),
        .reg_we_i     (we),
        .reg_addr_i   (addr),
        .reg_wdata_i  (wdata),
        .reg_gnt_o    (gnt),
        .reg_rvalid_o (rvalid),
        .reg_rdata_o  (rdata),
        .ext_irq_i    (ext),
        .irq_o        (irq),
        .time_irq_o   (tirq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One access per call; consecutive calls issue back-to-back requests.
    task automatic acc(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        exp_q.push_back(e);
        #1 check("gnt", gnt, 1);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        acc(1'b1, a, d, 32'h0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        acc(1'b0, a, 32'h0, e);
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata: unexpected response 0x%0h, none expected", rdata);
            end else begin
                exp_head = exp_q.pop_front();
                if (rdata !== exp_head) begin
                    errors++;
                    $display("FAIL rdata: got 0x%0h expected 0x%0h", rdata, exp_head);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Put live state in, then reset mid-run.
        wr(CPU_IRQ_TIMER_MTIMECMP_HI, 32'h0);
        wr(CPU_IRQ_TIMER_MTIMECMP_LO, 32'h0);
        wr(CPU_IRQ_TIMER_MTIME_LO, 32'd5);
        repeat (2) @(negedge clk);
        check("tirq_before_reset", tirq, 1);
        rst = 1'b1;
        #1;
        check("rst_tirq", tirq, 0);
        check("rst_irq", irq, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; req = 1'b1; we = 1'b0; addr = CPU_IRQ_TIMER_MTIME_LO;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1 req = 1'b0;
        rd(CPU_IRQ_TIMER_MTIMECMP_LO, 32'hFFFF_FFFF);
        rd(CPU_IRQ_TIMER_MTIMECMP_HI, 32'hFFFF_FFFF);

        // Prescale 3, compare 10: mtime steps every 4 cycles.
        wr(CPU_IRQ_TIMER_MTIMECMP_HI, 32'h0);
        wr(CPU_IRQ_TIMER_MTIMECMP_LO, 32'd10);
        wr(CPU_IRQ_TIMER_PRESCALE, 32'd3);
        wr(CPU_IRQ_TIMER_MTIME_LO, 32'd0);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd0);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd0);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd0);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd1);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd1);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd1);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd1);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd2);
        repeat (31) @(posedge clk);
        #1 check("tirq_at_mtime10", tirq, 0);
        @(posedge clk);
        #1 check("tirq_after_mtime10", tirq, 1);
        wr(CPU_IRQ_TIMER_MTIMECMP_LO, 32'd100);
        check("tirq_cmp_write_1", tirq, 1);
        @(posedge clk);
        #1 check("tirq_cmp_write_2", tirq, 0);

        // 64-bit wrap and write/increment collision.
        wr(CPU_IRQ_TIMER_PRESCALE, 32'd0);
        wr(CPU_IRQ_TIMER_MTIME_HI, 32'hFFFF_FFFF);
        wr(CPU_IRQ_TIMER_MTIME_LO, 32'hFFFF_FFFF);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'hFFFF_FFFF);
        rd(CPU_IRQ_TIMER_MTIME_HI, 32'h0);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'h1);
        wr(CPU_IRQ_TIMER_MTIME_LO, 32'd7);
        rd(CPU_IRQ_TIMER_MTIME_LO, 32'd7);

        // Edge-mode interrupt on line 0.
        wr(CPU_IRQ_TIMER_IRQ_MODE, 32'h1);
        wr(CPU_IRQ_TIMER_IRQ_ENABLE, 32'h1);
        @(negedge clk);
        ext[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check("edge_irq_latency", irq, 2'b00);
        end
        ext[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 check("edge_irq_held", irq, 2'b01);
        end
        rd(CPU_IRQ_TIMER_IRQ_PENDING, 32'h1);
        wr(CPU_IRQ_TIMER_IRQ_PENDING, 32'h1);
        check("edge_w1c_1", irq, 2'b01);
        @(posedge clk);
        #1 check("edge_w1c_2", irq, 2'b00);
        rd(CPU_IRQ_TIMER_IRQ_PENDING, 32'h0);
        @(negedge clk);
        ext[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(CPU_IRQ_TIMER_IRQ_PENDING, 32'h1);
        ext[0] = 1'b0;
        rd(CPU_IRQ_TIMER_IRQ_PENDING, 32'h1);
        wr(CPU_IRQ_TIMER_IRQ_PENDING, 32'h1);

        // Level-mode interrupt on line 1.
        wr(CPU_IRQ_TIMER_IRQ_MODE, 32'h0);
        wr(CPU_IRQ_TIMER_IRQ_ENABLE, 32'h2);
        @(negedge clk);
        ext[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("level_irq_latency", irq, 2'b00);
        @(posedge clk);
        #1 check("level_irq_set", irq, 2'b10);
        wr(CPU_IRQ_TIMER_IRQ_PENDING, 32'h2);
        repeat (2) @(posedge clk);
        #1 check("level_w1c_ignored", irq, 2'b10);
        rd(CPU_IRQ_TIMER_IRQ_PENDING, 32'h2);
        wr(CPU_IRQ_TIMER_IRQ_ENABLE, 32'h0);
        @(posedge clk);
        #1 check("level_masked", irq, 2'b00);
        rd(CPU_IRQ_TIMER_IRQ_PENDING, 32'h2);
        wr(CPU_IRQ_TIMER_IRQ_ENABLE, 32'h2);
        @(posedge clk);
        #1 check("level_unmasked", irq, 2'b10);
        @(negedge clk);
        ext[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("level_release_2", irq, 2'b10);
        @(posedge clk);
        #1 check("level_release_3", irq, 2'b00);

        // Bus protocol corners.
        wr(CPU_IRQ_TIMER_PRESCALE, 32'h1234_BEEF);
        rd(CPU_IRQ_TIMER_PRESCALE, 32'h0000_BEEF);
        rd(8'h3C, 32'h0);
        wr(8'h3C, 32'hDEAD_BEEF);
        rd(8'h3C, 32'h0);
        rd(8'h1A, 32'h2);
        rd(CPU_IRQ_TIMER_IRQ_MODE, 32'h0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_irq_timer.md
# cpu_irq_timer

Interrupt source stage that sits directly upstream of the CPU subsystem. It generates the machine timer interrupt from a 64-bit `mtime`/`mtimecmp` pair and conditions two external asynchronous interrupt lines (synchronise, edge/level select, pending, enable). Its outputs drive the subsystem's timer-interrupt and level-interrupt inputs. It is programmed through a simple single-cycle register port that the interconnect bridges from the CPU bus.

## Interface
Parameters:
- `NUM_IRQ`, 2, number of external interrupt lines; fixed to match the CPU level-interrupt width.
- `ADDR_W`, 8, register port byte-address width.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `reg_req_i`  in  1  register access request.
- `reg_we_i`  in  1  1 = write, 0 = read.
- `reg_addr_i`  in  ADDR_W  byte address; bits [1:0] ignored.
- `reg_wdata_i`  in  32  write data.
- `reg_gnt_o`  out  1  grant; equals `reg_req_i` combinationally.
- `reg_rvalid_o`  out  1  response valid, one cycle after grant (reads and writes).
- `reg_rdata_o`  out  32  read data; 0 when `reg_rvalid_o` is low and for writes.
- `ext_irq_i`  in  NUM_IRQ  asynchronous external interrupt lines.
- `irq_o`  out  NUM_IRQ  to CPU level interrupts; registered.
- `time_irq_o`  out  1  to CPU timer interrupt; registered.

## Operation
Register map (32-bit, word offsets):
- 0x00 `MTIME_LO`, 0x04 `MTIME_HI`: RW; reset 0.
- 0x08 `MTIMECMP_LO`, 0x0C `MTIMECMP_HI`: RW; reset 0xFFFF_FFFF each.
- 0x10 `PRESCALE`: RW [15:0]; reset 0. `mtime` increments every `PRESCALE+1` cycles.
- 0x14 `IRQ_PENDING`: R; W1C [NUM_IRQ-1:0].
- 0x18 `IRQ_ENABLE`: RW [NUM_IRQ-1:0]; reset 0.
- 0x1C `IRQ_MODE`: RW [NUM_IRQ-1:0]; 1 = rising-edge, 0 = level; reset 0.
- Unmapped addresses: reads return 0; writes are ignored; the access is still granted and answered.

Timer:
- A 16-bit prescale counter counts 0..PRESCALE. At the terminal count it returns to 0 and `mtime` increments by 1.
- `mtime` is 64 bits and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Carry propagates from LO to HI in the same cycle.
- A CPU write to either `mtime` half overrides the increment in that cycle. The written half takes `wdata`. The other half holds; no carry is applied.
- A write to `PRESCALE` clears the prescale counter.
- Comparison is unsigned 64-bit: `time_irq_o` is the registered value of `mtime >= mtimecmp`. It stays asserted until `mtimecmp` or `mtime` is rewritten.

External interrupts:
- Each line passes through a 2-flop synchroniser, then a previous-sample flop for edge detection.
- Edge mode: `pending` is set on a synchronised 0→1 transition and cleared by W1C. When set and clear occur in the same cycle, set wins.
- Level mode: `pending` is loaded with the synchronised level every cycle; W1C has no effect.
- Changing `IRQ_MODE` leaves `pending` unchanged until the next update under the new mode.
- `irq_o` is the registered value of `pending & IRQ_ENABLE`.

## Timing
- Reset (async assert, synchronous deassert handled upstream) sets:
  - all outputs to 0;
  - synchronisers and `pending` to 0;
  - `mtime` to 0 and `mtimecmp` to all-ones, so `time_irq_o` = 0.
- Register access: `reg_gnt_o` is asserted in the same cycle as `reg_req_i`. `reg_rvalid_o` and `reg_rdata_o` follow one cycle later. Back-to-back accesses every cycle are supported.
- Read data reflects register state before any write in the same cycle.
- A write is visible to a read on the next request.
- The effect of a write on `time_irq_o` appears 2 cycles after the write request: the register updates, then the compare register updates.
- `ext_irq_i` rising, first sampled at edge 0, produces:
  - sync2 at edge 1;
  - `pending` at edge 2;
  - `irq_o` at edge 3, when enabled.
- Latency to `irq_o` is the same in level and edge modes.
- `mtime` reaching `mtimecmp` at edge N asserts `time_irq_o` at edge N+1.
- Reset asserted mid-operation clears all state immediately. No partial register write is retained.

## Structure
- Register offsets, reset values and `IRQ_MODE` encodings are defined as localparams in `core_v_mcu_pkg` (`CPU_IRQ_TIMER_*`). The address decoder and the software driver both use them.
- One sub-module, `cpu_irq_sync`: the 2-flop synchroniser plus edge detect, instantiated NUM_IRQ times, with async active-high reset.
- Everything else is flat in `cpu_irq_timer`.

## Test plan
- Reset values: assert `rst_i` mid-run with `mtime` = 5, then release → all outputs are 0, `MTIME_LO` reads 0, `MTIMECMP_LO` reads 0xFFFF_FFFF.
- Prescale and compare: `PRESCALE` = 3, `MTIMECMP` = 10 → `mtime` steps every 4 cycles; `time_irq_o` rises exactly 1 cycle after `mtime` = 10; writing `MTIMECMP_LO` = 100 drops it 2 cycles later.
- Wrap and collision: `MTIME` = 0xFFFF_FFFF_FFFF_FFFF with `PRESCALE` = 0 → next cycle `mtime` = 0. A `MTIME_LO` write of 7 in the same cycle as an increment → reads 7.
- Edge interrupt: `IRQ_MODE` = 0b01, `IRQ_ENABLE` = 0b01, pulse `ext_irq_i[0]` for 3 cycles → `irq_o[0]` high 3 cycles after first sampling and held after the pulse. W1C 0x1 → low. Pulse edge coinciding with W1C → pending stays 1.
- Level interrupt: `IRQ_MODE` = 0, `IRQ_ENABLE` = 0b10, hold `ext_irq_i[1]` high → `irq_o[1]` = 1; W1C is ignored. Release → `irq_o[1]` = 0 after 3 cycles. Enable = 0 masks the output while `IRQ_PENDING` still reads 0b10.
- Bus protocol: back-to-back write then read to `PRESCALE` → read returns the written value. Read of 0x3C → 0, with `reg_rvalid_o` asserted.
